// File: rtl/debounce_fsm_pkg.sv
// debounce_fsm_pkg: shared state encodings and defaults for the tick-driven debouncer
// and any multi-button wrapper built around it.
`default_nettype none

package debounce_fsm_pkg;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'b00,
    ST_WAIT1 = 2'b01,
    ST_ONE   = 2'b10,
    ST_WAIT0 = 2'b11
  } db_state_t;

  localparam int N_TICKS_DEFAULT = 3;
  localparam int CNT_W_DEFAULT   = 4;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, asynchronous active-low reset to 0.
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/debounce_fsm.sv
// debounce_fsm: tick-driven switch debouncer with registered rise/fall strobes.
// Define DEBOUNCE_SYNC_EN to pass sw_in through a 2-FF synchroniser first.
`default_nettype none

module debounce_fsm
  import debounce_fsm_pkg::*;
#(
  parameter int N_TICKS = N_TICKS_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw_in,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(N_TICKS - 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  logic             w_sw_s;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rise;
  logic             r_fall;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sw_in),
    .o_q   (w_sw_s)
  );
`else
  assign w_sw_s = sw_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ZERO;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // A level reversal in a WAIT state is checked before the tick, so abort wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_ZERO: begin
        if (w_sw_s) begin
          w_state_nxt = ST_WAIT1;
          w_cnt_nxt   = C_RELOAD;
        end
      end
      ST_WAIT1: begin
        if (!w_sw_s) begin
          w_state_nxt = ST_ZERO;
        end else if (tick) begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_ONE;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - C_ONE;
          end
        end
      end
      ST_ONE: begin
        if (!w_sw_s) begin
          w_state_nxt = ST_WAIT0;
          w_cnt_nxt   = C_RELOAD;
        end
      end
      ST_WAIT0: begin
        if (w_sw_s) begin
          w_state_nxt = ST_ONE;
        end else if (tick) begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_ZERO;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - C_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_ZERO;
      end
    endcase
  end

  // ONE and WAIT0 share bit 1 of the encoding, so the level is a plain register bit.
  assign db_level = r_state[1];
  assign db_rise  = r_rise;
  assign db_fall  = r_fall;

endmodule

`default_nettype wire

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed and randomized checks of debounce_fsm against a
// run-length/tick-count reference model. Honors DEBOUNCE_SYNC_EN like the RTL.
`default_nettype none

module tb_debounce_fsm;

  localparam int N = 3;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick  = 1'b0;
  logic sw_in = 1'b0;
  logic db_level;
  logic db_rise;
  logic db_fall;

  always #5 clk = ~clk;

  debounce_fsm #(.N_TICKS(N), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .sw_in    (sw_in),
    .db_level (db_level),
    .db_rise  (db_rise),
    .db_fall  (db_fall)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   phase     = 0;
  logic tick_hold = 1'b0;
  int   nrise     = 0;
  int   nfall     = 0;

  // Reference: the level flips once the filtered input has disagreed with it on
  // every edge since divergence began and N ticks arrived after that first edge.
  logic m_lvl = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  logic m_pend = 1'b0, h0 = 1'b0, h1 = 1'b0, s;
  int   m_tc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lvl = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_pend = 1'b0; m_tc = 0; h0 = 1'b0; h1 = 1'b0;
    end else begin
      s  = (SL == 2) ? h1 : sw_in;
      h1 = h0;
      h0 = sw_in;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_lvl) begin
        if (!m_pend) begin
          m_pend = 1'b1;
          m_tc   = 0;
        end else if (tick) begin
          m_tc = m_tc + 1;
          if (m_tc == N) begin
            m_lvl  = s;
            m_rise = s;
            m_fall = ~s;
            m_pend = 1'b0;
          end
        end
      end else begin
        m_pend = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic sw);
    @(negedge clk);
    chk("level", db_level, m_lvl);
    chk("rise", db_rise, m_rise);
    chk("fall", db_fall, m_fall);
    nrise += int'(db_rise);
    nfall += int'(db_fall);
    sw_in = sw;
    tick  = (phase == 9) || tick_hold;
    phase = (phase + 1) % 10;
  endtask

  task automatic run(input int n, input logic sw);
    for (int i = 0; i < n; i++) cyc(sw);
  endtask

  task automatic align(input int p);
    while (phase != p) cyc(sw_in);
  endtask

  int r0;
  int f0;

  initial begin
    // Reset held with the switch already high.
    sw_in = 1'b1;
    #23;
    chk("rst_level", db_level, 1'b0);
    chk("rst_rise", db_rise, 1'b0);
    chk("rst_fall", db_fall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = nrise;
    run(45, 1'b1);
    chk("post_rst_level", db_level, 1'b1);
    chk("post_rst_one_rise", logic'(nrise - r0 == 1), 1'b1);

    // Clean press.
    run(40, 1'b0);
    chk("low_level", db_level, 1'b0);
    r0 = nrise;
    run(40, 1'b1);
    chk("press_level", db_level, 1'b1);
    chk("press_one_rise", logic'(nrise - r0 == 1), 1'b1);

    // Short glitch never accepted.
    run(40, 1'b0);
    r0 = nrise;
    run(15, 1'b1);
    run(40, 1'b0);
    chk("glitch_no_rise", logic'(nrise == r0), 1'b1);
    chk("glitch_level", db_level, 1'b0);

    // Reversal lands on the tick that would have accepted the fall.
    run(40, 1'b1);
    align(0);
    f0 = nfall;
    run(29 - SL, 1'b0);
    run(30, 1'b1);
    chk("abort_no_fall", logic'(nfall == f0), 1'b1);
    chk("abort_level", db_level, 1'b1);

    // Clean release.
    f0 = nfall;
    run(40, 1'b0);
    chk("release_one_fall", logic'(nfall - f0 == 1), 1'b1);
    chk("release_level", db_level, 1'b0);

    // Reset while waiting with one tick already counted.
    align(0);
    r0 = nrise;
    run(12, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_level", db_level, 1'b0);
    chk("midrst_rise", db_rise, 1'b0);
    chk("midrst_fall", db_fall, 1'b0);
    run(3, 1'b1);
    chk("midrst_no_rise", logic'(nrise == r0), 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run(40, 1'b1);
    chk("after_midrst_level", db_level, 1'b1);

    // Randomized bouncing, occasionally with tick held high.
    for (int k = 0; k < 60; k++) begin
      tick_hold = ($urandom_range(0, 7) == 0);
      run(int'($urandom_range(1, 45)), logic'($urandom_range(0, 1)));
    end
    tick_hold = 1'b0;
    run(40, 1'b0);
    chk("final_level", db_level, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
